// File: rtl/fsm_estado_param_pkg.sv
// Mood codes shared by the pet FSM and the display/sprite logic, plus the test-mode step order.
package fsm_estado_param_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    NEUTRO     = 3'd0,
    FELIZ      = 3'd1,
    TRISTE     = 3'd2,
    CANSADO    = 3'd3,
    HAMBRIENTO = 3'd4,
    MUERTO     = 3'd5
  } estado_t;

  // Each test button edge advances one step; MUERTO wraps back to NEUTRO.
  function automatic estado_t siguiente(input estado_t e);
    case (e)
      NEUTRO:     siguiente = FELIZ;
      FELIZ:      siguiente = TRISTE;
      TRISTE:     siguiente = CANSADO;
      CANSADO:    siguiente = HAMBRIENTO;
      HAMBRIENTO: siguiente = MUERTO;
      default:    siguiente = NEUTRO;
    endcase
  endfunction

endpackage

// File: rtl/fsm_estado_param_filtro.sv
// Persistence filter: ok once din has been high for N consecutive edges; 1-edge latency, no backpressure.
module filtro_persistencia #(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic ok
);

  localparam logic [CW-1:0] LIM = CW'(N);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (!din)
      cnt <= '0;
    else if (cnt != LIM)
      cnt <= cnt + 1'b1;
  end

  assign ok = (cnt == LIM);

endmodule

// File: rtl/fsm_estado_param.sv
// Pet-mood FSM with thresholds, dwell hysteresis, death latch and button-driven test mode.
// Input to estado latency is one edge once dwell is met; no backpressure, inputs sampled every cycle.
module fsm_estado_param
  import fsm_estado_param_pkg::*;
#(
  parameter int W            = 3,
  parameter int CNT_W        = 8,
  parameter int HAMBRE_MUERTE = 5,
  parameter int HAMBRE_ALTA  = 4,
  parameter int HAMBRE_BAJA  = 1,
  parameter int DIV_BAJA     = 1,
  parameter int DIV_ALTA     = 5,
  parameter int ENERGIA_BAJA = 1,
  parameter int RUIDO_MIN    = 3,
  parameter int MIN_DWELL    = 4,
  parameter int TEST_TIMEOUT = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             test,
  input  logic [W-1:0]     hambre,
  input  logic [W-1:0]     diversion,
  input  logic [W-1:0]     energia,
  input  logic             ultrasonido,
  input  logic             ruido,
  output logic [ST_W-1:0]  estado,
  output logic             cambio,
  output logic             modo_test,
  output logic             muerto_lat,
  output logic [CNT_W-1:0] tiempo_estado
);

  localparam logic [W-1:0]     TH_MUERTE  = W'(HAMBRE_MUERTE);
  localparam logic [W-1:0]     TH_H_ALTA  = W'(HAMBRE_ALTA);
  localparam logic [W-1:0]     TH_H_BAJA  = W'(HAMBRE_BAJA);
  localparam logic [W-1:0]     TH_D_BAJA  = W'(DIV_BAJA);
  localparam logic [W-1:0]     TH_D_ALTA  = W'(DIV_ALTA);
  localparam logic [W-1:0]     TH_E_BAJA  = W'(ENERGIA_BAJA);
  localparam logic [CNT_W-1:0] DWELL_LIM  = CNT_W'(MIN_DWELL - 1);
  localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TEST_TIMEOUT - 1);
  localparam int               RCW        = $clog2(RUIDO_MIN + 1);

  estado_t          st, st_nxt, cand;
  logic             test_q, test_edge, ruido_ok;
  logic             modo_nxt, lat_nxt;
  logic [CNT_W-1:0] tmo, tmo_nxt;

  filtro_persistencia #(
    .N  (RUIDO_MIN),
    .CW (RCW)
  ) u_ruido (
    .clk   (clk),
    .reset (reset),
    .din   (ruido),
    .ok    (ruido_ok)
  );

  assign test_edge = test & ~test_q;

  always_comb begin
    cand = NEUTRO;
    if (hambre >= TH_MUERTE)
      cand = MUERTO;
    else if (hambre >= TH_H_ALTA)
      cand = HAMBRIENTO;
    else if (ruido_ok || energia <= TH_E_BAJA)
      cand = CANSADO;
    else if (diversion <= TH_D_BAJA && ultrasonido)
      cand = TRISTE;
    else if (diversion >= TH_D_ALTA && hambre <= TH_H_BAJA && !ultrasonido)
      cand = FELIZ;
  end

  always_comb begin
    st_nxt   = st;
    modo_nxt = modo_test;
    lat_nxt  = muerto_lat;
    tmo_nxt  = tmo;
    if (st > MUERTO) begin
      st_nxt = NEUTRO;
    end else if (muerto_lat) begin
      st_nxt = MUERTO;
    end else if (!modo_test) begin
      // Death beats a simultaneous button edge and ignores dwell.
      if (cand == MUERTO) begin
        st_nxt  = MUERTO;
        lat_nxt = 1'b1;
      end else if (test_edge) begin
        modo_nxt = 1'b1;
        st_nxt   = siguiente(st);
        tmo_nxt  = '0;
      end else if (cand != st && tiempo_estado >= DWELL_LIM) begin
        st_nxt = cand;
      end
    end else if (test_edge) begin
      st_nxt  = siguiente(st);
      tmo_nxt = '0;
    end else if (tmo == TMO_LIM) begin
      modo_nxt = 1'b0;
      st_nxt   = cand;
      lat_nxt  = (cand == MUERTO);
      tmo_nxt  = '0;
    end else begin
      tmo_nxt = tmo + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= NEUTRO;
      cambio        <= 1'b0;
      modo_test     <= 1'b0;
      muerto_lat    <= 1'b0;
      tiempo_estado <= '0;
      tmo           <= '0;
      test_q        <= test;
    end else begin
      st         <= st_nxt;
      cambio     <= (st_nxt != st);
      modo_test  <= modo_nxt;
      muerto_lat <= lat_nxt;
      tmo        <= tmo_nxt;
      test_q     <= test;
      if (st_nxt != st)
        tiempo_estado <= '0;
      else if (tiempo_estado != '1)
        tiempo_estado <= tiempo_estado + 1'b1;
    end
  end

  assign estado = st;

endmodule

// File: tb/tb_fsm_estado_param.sv
// Directed bench for fsm_estado_param: behavioural mood model checked every cycle plus literal checkpoints.
module tb_fsm_estado_param;

  localparam int W = 3;
  localparam int CNT_W = 8;
  localparam int HAMBRE_MUERTE = 5, HAMBRE_ALTA = 4, HAMBRE_BAJA = 1;
  localparam int DIV_BAJA = 1, DIV_ALTA = 5, ENERGIA_BAJA = 1;
  localparam int RUIDO_MIN = 3, MIN_DWELL = 4, TEST_TIMEOUT = 50;
  localparam int WMOD = 1 << W;
  localparam int TMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, test, ultrasonido, ruido;
  logic [W-1:0]     hambre, diversion, energia;
  logic [2:0]       estado;
  logic             cambio, modo_test, muerto_lat;
  logic [CNT_W-1:0] tiempo_estado;

  int n_chk = 0;
  int n_fail = 0;

  fsm_estado_param #(
    .W(W), .CNT_W(CNT_W),
    .HAMBRE_MUERTE(HAMBRE_MUERTE), .HAMBRE_ALTA(HAMBRE_ALTA), .HAMBRE_BAJA(HAMBRE_BAJA),
    .DIV_BAJA(DIV_BAJA), .DIV_ALTA(DIV_ALTA), .ENERGIA_BAJA(ENERGIA_BAJA),
    .RUIDO_MIN(RUIDO_MIN), .MIN_DWELL(MIN_DWELL), .TEST_TIMEOUT(TEST_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .test(test),
    .hambre(hambre), .diversion(diversion), .energia(energia),
    .ultrasonido(ultrasonido), .ruido(ruido),
    .estado(estado), .cambio(cambio), .modo_test(modo_test),
    .muerto_lat(muerto_lat), .tiempo_estado(tiempo_estado)
  );

  always #5 clk = ~clk;

  // Mood model: states as plain numbers, "cycles in state" and "idle edges in test mode" as counters.
  int m_est, m_modo, m_lat, m_t, m_chg, m_run, m_idle;
  bit m_tprev, m_valid = 1'b0;

  function automatic int mood(int h, int d, int e, int us, int noisy);
    if (h >= HAMBRE_MUERTE % WMOD) return 5;
    if (h >= HAMBRE_ALTA % WMOD) return 4;
    if (noisy != 0 || e <= ENERGIA_BAJA % WMOD) return 3;
    if (d <= DIV_BAJA % WMOD && us != 0) return 2;
    if (d >= DIV_ALTA % WMOD && h <= HAMBRE_BAJA % WMOD && us == 0) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int c, old;
    bit press;
    if (reset) begin
      m_est = 0; m_modo = 0; m_lat = 0; m_t = 0; m_chg = 0;
      m_run = 0; m_idle = 0; m_tprev = test; m_valid = 1'b1;
    end else if (m_valid) begin
      c = mood(int'(hambre), int'(diversion), int'(energia), int'(ultrasonido),
               int'(m_run >= RUIDO_MIN));
      press = test && !m_tprev;
      old = m_est;
      if (m_lat != 0) begin
        m_est = 5;
      end else if (m_modo == 0) begin
        if (c == 5) begin
          m_est = 5; m_lat = 1;
        end else if (press) begin
          m_modo = 1; m_est = (m_est + 1) % 6; m_idle = 0;
        end else if (c != m_est && m_t + 1 >= MIN_DWELL) begin
          m_est = c;
        end
      end else if (press) begin
        m_est = (m_est + 1) % 6; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TEST_TIMEOUT) begin
          m_modo = 0; m_est = c; m_idle = 0;
          if (c == 5) m_lat = 1;
        end
      end
      m_chg = int'(m_est != old);
      m_t = (m_chg != 0) ? 0 : ((m_t < TMAX) ? m_t + 1 : TMAX);
      m_run = ruido ? m_run + 1 : 0;
      m_tprev = test;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        n_chk++;
        if (int'(estado) != m_est || int'(cambio) != m_chg || int'(modo_test) != m_modo ||
            int'(muerto_lat) != m_lat || int'(tiempo_estado) != m_t) begin
          n_fail++;
          $display("FAIL model t=%0t: got estado=%0d cambio=%0d modo=%0d lat=%0d t=%0d, expected %0d %0d %0d %0d %0d",
                   $time, estado, cambio, modo_test, muerto_lat, tiempo_estado,
                   m_est, m_chg, m_modo, m_lat, m_t);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; test = 1'b1; hambre = '0; diversion = '0; energia = 3'd4;
    ultrasonido = 1'b0; ruido = 1'b0;
    cyc(3);
    chk("rst_estado", int'(estado), 0);
    chk("rst_cambio", int'(cambio), 0);
    chk("rst_modo", int'(modo_test), 0);
    chk("rst_lat", int'(muerto_lat), 0);
    chk("rst_tiempo", int'(tiempo_estado), 0);

    // Button held through reset must not count as an edge.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("held_estado", int'(estado), 0);
      chk("held_modo", int'(modo_test), 0);
      chk("held_cambio", int'(cambio), 0);
    end
    test = 1'b0;
    cyc(2);

    for (int k = 1; k <= 6; k++) begin
      test = 1'b1;
      cyc(1);
      chk("pulse_estado", int'(estado), k % 6);
      chk("pulse_cambio", int'(cambio), 1);
      chk("pulse_modo", int'(modo_test), 1);
      test = 1'b0;
      cyc(1);
    end
    cyc(48);
    chk("tmo_49_modo", int'(modo_test), 1);
    cyc(1);
    chk("tmo_50_modo", int'(modo_test), 0);
    chk("tmo_50_estado", int'(estado), 0);

    cyc(10);
    diversion = 3'd1; ultrasonido = 1'b1;
    cyc(1);
    chk("dwell_triste", int'(estado), 2);
    chk("dwell_triste_cambio", int'(cambio), 1);
    diversion = 3'd5; ultrasonido = 1'b0; hambre = 3'd0;
    cyc(3);
    chk("dwell_hold_estado", int'(estado), 2);
    chk("dwell_hold_tiempo", int'(tiempo_estado), 3);
    cyc(1);
    chk("dwell_feliz", int'(estado), 1);
    chk("dwell_feliz_tiempo", int'(tiempo_estado), 0);

    cyc(6);
    ruido = 1'b1; cyc(2); ruido = 1'b0; cyc(3);
    chk("noise_short", int'(estado), 1);
    ruido = 1'b1;
    cyc(3);
    chk("noise_3", int'(estado), 1);
    cyc(1);
    chk("noise_cansado", int'(estado), 3);
    ruido = 1'b0;

    hambre = 3'd5;
    cyc(1);
    chk("death_estado", int'(estado), 5);
    chk("death_lat", int'(muerto_lat), 1);
    chk("death_cambio", int'(cambio), 1);
    hambre = 3'd0;
    for (int i = 0; i < 3; i++) begin
      test = 1'b1; cyc(1);
      chk("latched_estado", int'(estado), 5);
      chk("latched_modo", int'(modo_test), 0);
      test = 1'b0; cyc(1);
    end
    reset = 1'b1; cyc(1);
    chk("unlatch_estado", int'(estado), 0);
    chk("unlatch_lat", int'(muerto_lat), 0);
    reset = 1'b0;
    diversion = 3'd0;

    cyc(2);
    hambre = 3'd5; test = 1'b1;
    cyc(1);
    chk("simul_estado", int'(estado), 5);
    chk("simul_modo", int'(modo_test), 0);
    chk("simul_lat", int'(muerto_lat), 1);
    test = 1'b0; hambre = 3'd0;

    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    test = 1'b1; cyc(1);
    chk("midtest_modo", int'(modo_test), 1);
    chk("midtest_estado", int'(estado), 1);
    test = 1'b0; cyc(3);
    reset = 1'b1; cyc(1);
    chk("midtest_rst_modo", int'(modo_test), 0);
    chk("midtest_rst_estado", int'(estado), 0);
    reset = 1'b0;

    cyc(260);
    chk("sat_tiempo", int'(tiempo_estado), 255);
    chk("sat_estado", int'(estado), 0);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
